// File: rtl/tt_um_sample_flow_accum.sv
// Sample-flow accumulator with four update modes (linear wrap, quadratic
// wrap, bounce, saturate) sequenced by a small IDLE/RUN/HOLD/DONE machine.
// The accumulator never wraps modulo 2^WIDTH. Wide intermediate sums are
// clamped to the all-ones value before they are registered.
module tt_um_sample_flow_accum #(
    parameter int WIDTH      = 8,
    parameter int LIMIT      = 50,
    parameter int STEP_SHIFT = 2,
    parameter int QUAD_SHIFT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_HOLD = 2'b10,
        S_DONE = 2'b11
    } state_t;

    // Intermediate arithmetic width: wide enough that acc+inc+square never overflows.
    localparam int SW = 2 * WIDTH + 1;
    localparam logic [SW-1:0]    ACC_MAX = SW'((1 << WIDTH) - 1);
    localparam logic [WIDTH-1:0] LIM_W   = WIDTH'(LIMIT);
    localparam logic [SW-1:0]    LIM_X   = SW'(LIMIT);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             dir_q, dir_d;
    logic             wrap_q, wrap_d;

    logic       run;
    logic [1:0] mode;
    logic [7:0] inc;
    logic       unused_uio;

    logic [SW-1:0] acc_x;
    logic [SW-1:0] inc_x;
    logic [SW-1:0] quad_base;
    logic [SW-1:0] quad_sq;
    logic [SW-1:0] sum_lin;
    logic [SW-1:0] sum_quad;

    assign run        = uio_in[0];
    assign mode       = uio_in[3:2];
    assign unused_uio = ^{uio_in[7:4], uio_in[1]};
    assign inc        = ui_in >> STEP_SHIFT;

    // Datapath: zero-extended operands and the two candidate sums.
    assign acc_x     = SW'(acc_q);
    assign inc_x     = SW'(inc);
    assign quad_base = SW'(acc_q >> QUAD_SHIFT);
    assign quad_sq   = quad_base * quad_base;
    assign sum_lin   = acc_x + inc_x;
    assign sum_quad  = acc_x + inc_x + quad_sq;

    // Clamp a wide sum to the largest representable accumulator value.
    function automatic logic [WIDTH-1:0] sat(input logic [SW-1:0] v);
        if (v > ACC_MAX) begin
            sat = ACC_MAX[WIDTH-1:0];
        end else begin
            sat = v[WIDTH-1:0];
        end
    endfunction

    // Next-state and accumulator update; ena low freezes everything including the pulse.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        dir_d   = dir_q;
        wrap_d  = 1'b0;
        if (!ena) begin
            wrap_d = wrap_q;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (run) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    // Only bounce mode tracks direction; elsewhere it reads as "up".
                    if (mode != 2'b10) begin
                        dir_d = 1'b1;
                    end
                    if (!run) begin
                        state_d = S_HOLD;
                    end else begin
                        case (mode)
                            2'b00: begin
                                if (acc_q >= LIM_W) begin
                                    acc_d  = '0;
                                    wrap_d = 1'b1;
                                end else begin
                                    acc_d = sat(sum_lin);
                                end
                            end
                            2'b01: begin
                                if (acc_q >= LIM_W) begin
                                    acc_d  = '0;
                                    wrap_d = 1'b1;
                                end else begin
                                    acc_d = sat(sum_quad);
                                end
                            end
                            2'b10: begin
                                if (dir_q) begin
                                    if (sum_lin >= LIM_X) begin
                                        acc_d = LIM_W;
                                        dir_d = 1'b0;
                                    end else begin
                                        acc_d = sat(sum_lin);
                                    end
                                end else begin
                                    if (acc_x <= inc_x) begin
                                        acc_d  = '0;
                                        dir_d  = 1'b1;
                                        wrap_d = 1'b1;
                                    end else begin
                                        acc_d = WIDTH'(acc_x - inc_x);
                                    end
                                end
                            end
                            default: begin
                                if (sum_lin >= LIM_X) begin
                                    acc_d   = LIM_W;
                                    state_d = S_DONE;
                                end else begin
                                    acc_d = sat(sum_lin);
                                end
                            end
                        endcase
                    end
                end
                S_HOLD: begin
                    if (run) begin
                        state_d = S_RUN;
                    end
                end
                default: begin
                    if (!run) begin
                        state_d = S_IDLE;
                        acc_d   = '0;
                    end
                end
            endcase
        end
    end

    // State register with immediate (asynchronous) reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            dir_q   <= 1'b1;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            dir_q   <= dir_d;
            wrap_q  <= wrap_d;
        end
    end

    assign uo_out  = acc_q[7:0];
    assign uio_out = {wrap_q, dir_q, state_q, 4'b0000};
    assign uio_oe  = 8'b1111_0000;

endmodule

// File: tb/tb_tt_um_sample_flow_accum.sv
// Bench for tt_um_sample_flow_accum: directed sequences plus randomized
// traffic, all checked against an integer reference model of the rules.
module tb_tt_um_sample_flow_accum;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int errors = 0;
    int checks = 0;

    // Reference model state (plain integers).
    int m_acc;
    int m_state;
    int m_dir;
    int m_wrap;

    localparam int LIM = 50;

    tt_um_sample_flow_accum dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int min255(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    // One enabled clock of the behaviour described by the rules.
    task automatic model_step();
        int run, mode, inc, s;
        if (!ena) return;
        run  = int'(uio_in[0]);
        mode = int'(uio_in[3:2]);
        inc  = int'(ui_in) / 4;
        m_wrap = 0;
        case (m_state)
            0: if (run == 1) m_state = 1;
            1: begin
                if (mode != 2) m_dir = 1;
                if (run == 0) m_state = 2;
                else if (mode == 0 || mode == 1) begin
                    if (m_acc >= LIM) begin
                        m_acc = 0;
                        m_wrap = 1;
                    end else if (mode == 0) begin
                        m_acc = min255(m_acc + inc);
                    end else begin
                        m_acc = min255(m_acc + inc + (m_acc / 8) * (m_acc / 8));
                    end
                end else if (mode == 2) begin
                    if (m_dir == 1) begin
                        s = m_acc + inc;
                        if (s >= LIM) begin
                            m_acc = LIM;
                            m_dir = 0;
                        end else m_acc = s;
                    end else if (m_acc <= inc) begin
                        m_acc = 0;
                        m_dir = 1;
                        m_wrap = 1;
                    end else m_acc = m_acc - inc;
                end else begin
                    s = m_acc + inc;
                    if (s >= LIM) begin
                        m_acc = LIM;
                        m_state = 3;
                    end else m_acc = s;
                end
            end
            2: if (run == 1) m_state = 1;
            default: if (run == 0) begin
                m_state = 0;
                m_acc = 0;
            end
        endcase
    endtask

    task automatic check_model(input string tag);
        check({tag, ".uo_out"}, int'(uo_out), m_acc % 256);
        check({tag, ".uio_out"}, int'(uio_out), m_wrap * 128 + m_dir * 64 + m_state * 16);
        check({tag, ".uio_oe"}, int'(uio_oe), 240);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_model(tag);
    endtask

    // Asynchronous reset pulse placed between clock edges; outputs must clear at once.
    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        m_acc = 0;
        m_state = 0;
        m_dir = 1;
        m_wrap = 0;
        check_model(tag);
        check({tag, ".rst_uio"}, int'(uio_out), 64);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_table(input string tag, input int mode, input int ui,
                             input int vals[$], input int dirs[$], input int wrap_idx);
        ui_in  = 8'(ui);
        uio_in = 8'((mode << 2) | 1);
        for (int i = 0; i < vals.size(); i++) begin
            tick(tag);
            check($sformatf("%s.acc[%0d]", tag, i), int'(uo_out), vals[i]);
            check($sformatf("%s.wrap[%0d]", tag, i), int'(uio_out[7]), (i == wrap_idx) ? 1 : 0);
            if (dirs.size() > 0)
                check($sformatf("%s.dir[%0d]", tag, i), int'(uio_out[6]), dirs[i]);
        end
    endtask

    initial begin
        int q_none[$];
        rst_n  = 1'b1;
        ena    = 1'b1;
        ui_in  = 8'd0;
        uio_in = 8'd0;
        q_none = {};
        m_acc = 0; m_state = 0; m_dir = 1; m_wrap = 0;

        // Reset state before any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check_model("reset");
        check("reset.uio_out", int'(uio_out), 64);
        #1;
        rst_n = 1'b1;

        // Linear wrap.
        run_table("lin", 0, 40, '{0, 10, 20, 30, 40, 50, 0}, q_none, 6);

        // Async reset mid-RUN with acc=30.
        do_reset("rst_pre");
        run_table("lin30", 0, 40, '{0, 10, 20, 30}, q_none, -1);
        do_reset("rst_run");
        check("rst_run.state", int'(uio_out[5:4]), 0);

        // Quadratic wrap.
        run_table("quad", 1, 8, '{0, 2, 4, 6, 8, 11, 14, 17, 23, 29, 40, 67, 0}, q_none, 12);

        // Bounce.
        do_reset("rst_b");
        run_table("bounce", 2, 80, '{0, 20, 40, 50, 30, 10, 0, 20},
                  '{1, 1, 1, 0, 0, 0, 1, 1}, 6);

        // Saturate into DONE, stay while run=1, leave on run=0.
        do_reset("rst_s");
        run_table("sat", 3, 80, '{0, 20, 40, 50}, q_none, -1);
        check("sat.state", int'(uio_out[5:4]), 3);
        for (int i = 0; i < 3; i++) tick("done_stay");
        check("done_stay.state", int'(uio_out[5:4]), 3);
        check("done_stay.acc", int'(uo_out), 50);
        uio_in = 8'h0C;
        tick("done_exit");
        check("done_exit.state", int'(uio_out[5:4]), 0);
        check("done_exit.acc", int'(uo_out), 0);

        // HOLD freeze, ena priority, resume.
        do_reset("rst_h");
        run_table("hold30", 0, 40, '{0, 10, 20, 30}, q_none, -1);
        uio_in = 8'h00;
        for (int i = 0; i < 6; i++) tick("hold");
        check("hold.state", int'(uio_out[5:4]), 2);
        check("hold.acc", int'(uo_out), 30);
        ena = 1'b0;
        uio_in = 8'h01;
        for (int i = 0; i < 3; i++) tick("ena_off");
        check("ena_off.state", int'(uio_out[5:4]), 2);
        check("ena_off.acc", int'(uo_out), 30);
        ena = 1'b1;
        tick("resume");
        check("resume.state", int'(uio_out[5:4]), 1);
        check("resume.acc", int'(uo_out), 30);
        tick("resume2");
        check("resume2.acc", int'(uo_out), 40);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            ena    = ($urandom_range(0, 9) != 0);
            ui_in  = 8'($urandom);
            uio_in = 8'($urandom);
            uio_in[0] = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 7) != 0) uio_in[3:2] = 2'(n / 97);
            if ($urandom_range(0, 299) == 0) do_reset("rnd_rst");
            else tick("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
